// File: rtl/urv_regfile_mp.sv
// urv_regfile_mp: multi-read-port register file with one shared write port.
// Each read port owns a private copy of the array, and every write goes to all
// copies. Reads are registered (one cycle of latency). The output for each port
// is chosen by priority: X-stage forward, then W-stage forward, then array data.
// Optional feature macro: URV_REGFILE_CLEAR_EN. When it is defined, a clear
// sequencer zeroes the whole array after reset, and busy_o is high while it runs.
// G_DEPTH must be 16 or 32. G_RD_PORTS must be in the range 1..4.
`default_nettype none

module urv_regfile_mp #(
  parameter int G_WIDTH    = 32,
  parameter int G_DEPTH    = 32,
  parameter int G_RD_PORTS = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            d_stall_i,
  input  logic [5*G_RD_PORTS-1:0]         rf_rs_i,
  input  logic [5*G_RD_PORTS-1:0]         d_rs_i,
  output logic [G_WIDTH*G_RD_PORTS-1:0]   x_rs_value_o,
  input  logic [4:0]                      w_rd_i,
  input  logic [G_WIDTH-1:0]              w_rd_value_i,
  input  logic                            w_rd_store_i,
  input  logic                            w_bypass_rd_write_i,
  input  logic [G_WIDTH-1:0]              w_bypass_rd_value_i,
  output logic                            busy_o
);

  // Array index width: 4 bits for RV32E (16 entries), 5 bits otherwise.
  localparam int AW = (G_DEPTH == 16) ? 4 : 5;

  logic              w_rd_in_range;
  logic              w_wr_eff;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [G_WIDTH-1:0] w_wdata;
  logic              w_force_zero;
  logic [G_WIDTH-1:0] r_wval_p1;

  // Pipeline write: discard writes to x0, writes beyond the array, and writes made while clearing.
  assign w_rd_in_range = ({1'b0, w_rd_i} < 6'(G_DEPTH));
  assign w_wr_eff      = w_rd_store_i & (w_rd_i != 5'd0) & w_rd_in_range & ~busy_o;

`ifdef URV_REGFILE_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  // Clear sequencer: after reset, write zero to each address in turn, then go to READY.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(G_DEPTH - 1)) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_READY;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = r_busy;

  // Write source select: the clear sequencer owns the write port while it runs.
  always_comb begin
    w_we    = w_wr_eff;
    w_waddr = w_rd_i[AW-1:0];
    w_wdata = w_rd_value_i;
    if (r_state == S_CLEAR) begin
      w_we    = rst_n_i;
      w_waddr = r_cnt;
      w_wdata = '0;
    end
  end
`else
  assign busy_o = 1'b0;

  // Write source select: while reset is held, only x0 is written, and it is written with zero.
  always_comb begin
    w_we    = w_wr_eff;
    w_waddr = w_rd_i[AW-1:0];
    w_wdata = w_rd_value_i;
    if (!rst_n_i) begin
      w_we    = 1'b1;
      w_waddr = '0;
      w_wdata = '0;
    end
  end
`endif

  // Outputs read zero while reset is held and while the array is being cleared.
  assign w_force_zero = busy_o | ~rst_n_i;

  // Write data is kept for the W-stage forward. Its per-port flags decide whether it is used.
  always_ff @(posedge clk_i) begin
    if (!d_stall_i) begin
      r_wval_p1 <= w_rd_value_i;
    end
  end

  for (genvar k = 0; k < G_RD_PORTS; k++) begin : g_port
    logic [G_WIDTH-1:0] r_mem [G_DEPTH];
    logic [4:0]         w_rs;
    logic [4:0]         w_ds;
    logic               w_rs_ok;
    logic               w_xbyp;
    logic [G_WIDTH-1:0] r_rdata_p1;
    logic               r_wbyp_p1;

    assign w_rs    = rf_rs_i[5*k +: 5];
    assign w_ds    = d_rs_i[5*k +: 5];
    assign w_rs_ok = (w_rs != 5'd0) && ({1'b0, w_rs} < 6'(G_DEPTH));
    assign w_xbyp  = w_bypass_rd_write_i && (w_rd_i == w_ds) && (w_rd_i != 5'd0);

    // This port's private copy of the array. It is written whenever any write happens.
    always_ff @(posedge clk_i) begin
      if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
    end

    // ---- stage p0 -> p1: capture array data and the same-edge write hit ----
    // Read capture: held during a decode stall. The flag marks a write landing on the captured address.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_rdata_p1 <= '0;
        r_wbyp_p1  <= 1'b0;
      end else if (!d_stall_i) begin
        r_rdata_p1 <= w_rs_ok ? r_mem[w_rs[AW-1:0]] : '0;
        r_wbyp_p1  <= w_wr_eff && (w_rd_i == w_rs);
      end
    end

    assign x_rs_value_o[k*G_WIDTH +: G_WIDTH] =
      w_force_zero ? '0 :
      w_xbyp       ? w_bypass_rd_value_i :
      r_wbyp_p1    ? r_wval_p1 :
                     r_rdata_p1;
  end

endmodule

`default_nettype wire
